// File: rtl/rng_uart_tx_pkg.sv
// Shared definitions for the TRNG byte packer / UART transmitter.
package rng_uart_tx_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/rng_byte_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module rng_byte_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             empty_q;
   logic             full_q;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty_q;
   assign do_push = push && (!full_q || do_pop);
   assign dout    = mem_q[rd_ptr_q];
   assign empty   = empty_q;
   assign full    = full_q;

   // Occupancy after this cycle's push/pop
   always_comb begin
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Pointers, occupancy and registered flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == CW'(DEPTH));
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/rng_uart_tx.sv
// TRNG bit collector: synchronizes the bit stream, packs bytes LSB first, buffers them and
// sends each as a UART 8N1 frame. Define VON_NEUMANN_EN to debias bit pairs before packing.
module rng_uart_tx
   import rng_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic random_Bit,
   input  logic low_Freq_Clk,
   input  logic tx_Enable,
   output logic uart_Tx,
   output logic tx_Busy,
   output logic fifo_Full,
   output logic overflow_Sticky
);

   localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_IDX_W = $clog2(UART_DATA_BITS);

   logic [SYNC_STAGES-1:0]    bit_sync_q;
   logic [SYNC_STAGES-1:0]    lfc_sync_q;
   logic                      lfc_prev_q;
   logic                      strobe_c;
   logic                      bit_s;
   logic                      pack_en_c;
   logic                      pack_bit_c;
   logic [BIT_IDX_W-1:0]      bit_cnt_q;
   logic [UART_DATA_BITS-1:0] pack_q;
   logic [UART_DATA_BITS-1:0] push_data_q;
   logic                      push_q;
   logic                      overflow_q;
   logic                      fifo_pop_c;
   logic                      fifo_empty;
   logic                      fifo_full;
   logic [UART_DATA_BITS-1:0] fifo_dout;
   tx_state_e                 state_q;
   logic [BAUD_W-1:0]         baud_q;
   logic                      baud_wrap_c;
   logic [BIT_IDX_W-1:0]      bit_idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      uart_q;
   logic                      busy_q;

   // Bring the TRNG bit and its strobe clock into the clk domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_sync_q <= '0;
         lfc_sync_q <= '0;
         lfc_prev_q <= 1'b0;
      end else begin
         bit_sync_q <= {bit_sync_q[SYNC_STAGES-2:0], random_Bit};
         lfc_sync_q <= {lfc_sync_q[SYNC_STAGES-2:0], low_Freq_Clk};
         lfc_prev_q <= lfc_sync_q[SYNC_STAGES-1];
      end
   end

   // Falling edge of the synced strobe clock: the bit has been stable for half a period
   assign strobe_c = lfc_prev_q & ~lfc_sync_q[SYNC_STAGES-1];
   assign bit_s    = bit_sync_q[SYNC_STAGES-1];

`ifdef VON_NEUMANN_EN
   logic pair_phase_q;
   logic pair_first_q;

   // Pair tracking: 01 -> 0, 10 -> 1, equal pairs are discarded
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pair_phase_q <= 1'b0;
         pair_first_q <= 1'b0;
      end else if (strobe_c) begin
         pair_phase_q <= ~pair_phase_q;
         if (!pair_phase_q) pair_first_q <= bit_s;
      end
   end

   assign pack_en_c  = strobe_c & pair_phase_q & (pair_first_q ^ bit_s);
   assign pack_bit_c = pair_first_q;
`else
   assign pack_en_c  = strobe_c;
   assign pack_bit_c = bit_s;
`endif

   // Packer: LSB-first bit assembly, byte handed to the FIFO the cycle after the 8th bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt_q   <= '0;
         pack_q      <= '0;
         push_data_q <= '0;
         push_q      <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (pack_en_c) begin
            pack_q[bit_cnt_q] <= pack_bit_c;
            if (bit_cnt_q == BIT_IDX_W'(UART_DATA_BITS - 1)) begin
               push_q      <= 1'b1;
               push_data_q <= {pack_bit_c, pack_q[UART_DATA_BITS-2:0]};
               bit_cnt_q   <= '0;
            end else begin
               bit_cnt_q <= bit_cnt_q + BIT_IDX_W'(1);
            end
         end
      end
   end

   // Sticky flag for a packed byte that found the FIFO full with no pop to make room
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else if (push_q && fifo_full && !fifo_pop_c) begin
         overflow_q <= 1'b1;
      end
   end

   rng_byte_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_q),
      .pop   (fifo_pop_c),
      .din   (push_data_q),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign fifo_pop_c  = (state_q == TX_IDLE) && tx_Enable && !fifo_empty;
   assign baud_wrap_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   // UART 8N1 transmitter with registered line and busy outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= TX_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         uart_q    <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            TX_IDLE: begin
               if (fifo_pop_c) begin
                  shift_q <= fifo_dout;
                  baud_q  <= '0;
                  uart_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= TX_START;
               end
            end
            TX_START: begin
               if (baud_wrap_c) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  uart_q    <= shift_q[0];
                  shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                  state_q   <= TX_DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            TX_DATA: begin
               if (baud_wrap_c) begin
                  baud_q <= '0;
                  if (bit_idx_q == BIT_IDX_W'(UART_DATA_BITS - 1)) begin
                     uart_q  <= 1'b1;
                     state_q <= TX_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
                     uart_q    <= shift_q[0];
                     shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            TX_STOP: begin
               if (baud_wrap_c) begin
                  baud_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= TX_IDLE;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: begin
               uart_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= TX_IDLE;
            end
         endcase
      end
   end

   assign uart_Tx         = uart_q;
   assign tx_Busy         = busy_q;
   assign fifo_Full       = fifo_full;
   assign overflow_Sticky = overflow_q;

endmodule
